// File: rtl/clk_div_pkg.sv
// Shared types, constants and the phase-length helper for the integer clock divider.
package clk_div_pkg;

    // Divider FSM state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HIGH = 2'b01,
        ST_LOW  = 2'b10
    } div_state_e;

    // Smallest ratio that actually divides; 0 and 1 mean "stay in bypass".
    localparam int unsigned MIN_RATIO = 2;

    // Returns {H, L} (32 bits each) for ratio r. For odd ratios the extra
    // reference cycle goes to the high phase when odd_high is set, otherwise
    // to the low phase. Working in 32 bits keeps (R+1)/2 from overflowing
    // at R = 2^RATIO_W-1 for any RATIO_W up to 32.
    function automatic logic [63:0] calc_phases(input logic [31:0] r,
                                                input logic        odd_high);
        logic [31:0] half_v;
        logic [31:0] h_v;
        logic [31:0] l_v;
        half_v = r >> 1;
        if (!r[0]) begin
            h_v = half_v;
            l_v = half_v;
        end else if (odd_high) begin
            h_v = half_v + 32'd1;
            l_v = half_v;
        end else begin
            h_v = half_v;
            l_v = half_v + 32'd1;
        end
        return {h_v, l_v};
    endfunction

endpackage

// File: rtl/clk_div_phase_calc.sv
// Combinational split of a latched ratio R into high/low phase lengths.
module clk_div_phase_calc
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_W  = 8,
    parameter int unsigned ODD_HIGH = 1
) (
    input  logic [RATIO_W-1:0] ratio_i,
    output logic [RATIO_W-1:0] high_len_o,
    output logic [RATIO_W-1:0] low_len_o
);

    logic [63:0] phases_s;

    // Compute {H, L} for the current ratio and narrow back to the counter width.
    always_comb begin
        phases_s   = calc_phases(32'(ratio_i), (ODD_HIGH != 0));
        high_len_o = RATIO_W'(phases_s >> 32);
        low_len_o  = RATIO_W'(phases_s);
    end

endmodule

// File: rtl/clk_divider_gen.sv
// Glitch-aware integer clock divider. Ratio and enable are only sampled in
// IDLE or at the end of a divided period, so no runt pulse can be produced.
// While IDLE the reference clock is passed straight through.
module clk_divider_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_W  = 8,
    parameter int unsigned ODD_HIGH = 1
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_clk_en,
    input  logic [RATIO_W-1:0] i_div_ratio,
    output logic               o_div_clk,
    output logic               o_tick,
    output logic               o_running,
    output logic [RATIO_W-1:0] o_active_ratio
);

    div_state_e         state_q, state_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic               div_q, div_d;
    logic               tick_q, tick_d;
    logic               running_q, running_d;

    logic [RATIO_W-1:0] high_len_s;
    logic [RATIO_W-1:0] low_len_s;
    logic               start_ok_s;

    // Phase lengths always follow the latched ratio, never the live input.
    clk_div_phase_calc #(
        .RATIO_W  (RATIO_W),
        .ODD_HIGH (ODD_HIGH)
    ) u_phase_calc (
        .ratio_i    (ratio_q),
        .high_len_o (high_len_s),
        .low_len_o  (low_len_s)
    );

    // A new period may start only when enabled with a dividing ratio.
    always_comb begin
        start_ok_s = i_clk_en && (i_div_ratio >= RATIO_W'(MIN_RATIO));
    end

    // Next-state, counter and output-register logic for the divider FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    ratio_d = i_div_ratio;
                    cnt_d   = RATIO_W'(1'b1);
                    div_d   = 1'b1;
                    tick_d  = 1'b1;
                    state_d = ST_HIGH;
                end else begin
                    ratio_d = {RATIO_W{1'b0}};
                    cnt_d   = {RATIO_W{1'b0}};
                    div_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                // '>=' rather than '==' so a corrupted counter still terminates the phase.
                if (cnt_q >= high_len_s) begin
                    cnt_d   = RATIO_W'(1'b1);
                    div_d   = 1'b0;
                    state_d = ST_LOW;
                end else begin
                    cnt_d   = cnt_q + RATIO_W'(1'b1);
                end
            end
            ST_LOW: begin
                if (cnt_q >= low_len_s) begin
                    // Period boundary: the only place enable/ratio are re-evaluated.
                    if (start_ok_s) begin
                        ratio_d = i_div_ratio;
                        cnt_d   = RATIO_W'(1'b1);
                        div_d   = 1'b1;
                        tick_d  = 1'b1;
                        state_d = ST_HIGH;
                    end else begin
                        ratio_d = {RATIO_W{1'b0}};
                        cnt_d   = {RATIO_W{1'b0}};
                        div_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + RATIO_W'(1'b1);
                end
            end
            default: begin
                ratio_d = {RATIO_W{1'b0}};
                cnt_d   = {RATIO_W{1'b0}};
                div_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
        running_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset drops straight back to bypass.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {RATIO_W{1'b0}};
            ratio_q   <= {RATIO_W{1'b0}};
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            running_q <= running_d;
        end
    end

    // Bypass the reference clock while IDLE, otherwise drive the divided phase.
    always_comb begin
        o_div_clk = (state_q == ST_IDLE) ? i_ref_clk : div_q;
    end

    // Status outputs come directly from registers.
    always_comb begin
        o_tick         = tick_q;
        o_running      = running_q;
        o_active_ratio = ratio_q;
    end

endmodule

// File: tb/tb_clk_divider_gen.sv
// Directed, table-driven bench for clk_divider_gen. Two instances share the
// stimulus: one with the odd extra cycle in the high phase, one in the low phase.
module tb_clk_divider_gen;

    typedef struct {
        logic       en;
        logic [7:0] ratio;
        logic       div;
        logic       tick;
        logic       run;
        logic [7:0] ar;
        logic       div0;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] ratio;

    logic       div_clk,  tick,  running;
    logic [7:0] act_ratio;
    logic       div_clk0, tick0, running0;
    logic [7:0] act_ratio0;

    int n_chk;
    int n_fail;
    vec_t vq[$];

    clk_divider_gen #(.RATIO_W(8), .ODD_HIGH(1)) dut (
        .i_ref_clk      (clk),
        .i_rst_n        (rst_n),
        .i_clk_en       (en),
        .i_div_ratio    (ratio),
        .o_div_clk      (div_clk),
        .o_tick         (tick),
        .o_running      (running),
        .o_active_ratio (act_ratio)
    );

    clk_divider_gen #(.RATIO_W(8), .ODD_HIGH(0)) dut0 (
        .i_ref_clk      (clk),
        .i_rst_n        (rst_n),
        .i_clk_en       (en),
        .i_div_ratio    (ratio),
        .o_div_clk      (div_clk0),
        .o_tick         (tick0),
        .o_running      (running0),
        .o_active_ratio (act_ratio0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic e, input logic [7:0] r, input logic d,
                                input logic t, input logic ru, input logic [7:0] a,
                                input logic d0);
        vec_t v;
        v.en = e; v.ratio = r; v.div = d; v.tick = t; v.run = ru; v.ar = a; v.div0 = d0;
        vq.push_back(v);
    endfunction

    // Drive each vector, sample just after the rising edge, then re-check the
    // clock output in the low half (bypass must follow the reference low).
    task automatic apply_vecs(input string tag);
        foreach (vq[i]) begin
            en    = vq[i].en;
            ratio = vq[i].ratio;
            @(posedge clk);
            #1;
            chk($sformatf("%s[%0d].div",   tag, i), 32'(div_clk),    32'(vq[i].div));
            chk($sformatf("%s[%0d].tick",  tag, i), 32'(tick),       32'(vq[i].tick));
            chk($sformatf("%s[%0d].run",   tag, i), 32'(running),    32'(vq[i].run));
            chk($sformatf("%s[%0d].ratio", tag, i), 32'(act_ratio),  32'(vq[i].ar));
            chk($sformatf("%s[%0d].div0",  tag, i), 32'(div_clk0),   32'(vq[i].div0));
            chk($sformatf("%s[%0d].tick0", tag, i), 32'(tick0),      32'(vq[i].tick));
            chk($sformatf("%s[%0d].run0",  tag, i), 32'(running0),   32'(vq[i].run));
            chk($sformatf("%s[%0d].ratio0",tag, i), 32'(act_ratio0), 32'(vq[i].ar));
            @(negedge clk);
            #1;
            chk($sformatf("%s[%0d].divlo",  tag, i), 32'(div_clk),  32'(vq[i].run ? vq[i].div  : 1'b0));
            chk($sformatf("%s[%0d].div0lo", tag, i), 32'(div_clk0), 32'(vq[i].run ? vq[i].div0 : 1'b0));
        end
        vq.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        ratio = 8'd0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, hi0, tk, tk0, rn;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        ratio  = 8'd0;

        // Reset state, sampled with the reference low and then high.
        #2;
        chk("rst.run",   32'(running),   32'd0);
        chk("rst.tick",  32'(tick),      32'd0);
        chk("rst.ratio", 32'(act_ratio), 32'd0);
        chk("rst.divlo", 32'(div_clk),   32'd0);
        #5;
        chk("rst.divhi", 32'(div_clk),   32'd1);
        #3;
        rst_n = 1'b1;

        // Divide by 4: 1100 repeating, tick at each period start.
        do_reset();
        for (int k = 0; k < 8; k++)
            add(1'b1, 8'd4, ((k % 4) < 2), ((k % 4) == 0), 1'b1, 8'd4, ((k % 4) < 2));
        apply_vecs("div4");

        // Divide by 5: high 3/low 2 (odd-high) and high 2/low 3 (odd-low).
        do_reset();
        for (int k = 0; k < 10; k++)
            add(1'b1, 8'd5, ((k % 5) < 3), ((k % 5) == 0), 1'b1, 8'd5, ((k % 5) < 2));
        apply_vecs("div5");

        // Divide by 255: 128/127 split, then a clean restart of the period.
        do_reset();
        en = 1'b1;
        ratio = 8'd255;
        hi = 0; hi0 = 0; tk = 0; tk0 = 0; rn = 0;
        for (int k = 0; k < 255; k++) begin
            @(posedge clk);
            #1;
            hi  += int'(div_clk);
            hi0 += int'(div_clk0);
            tk  += int'(tick);
            tk0 += int'(tick0);
            rn  += int'(running);
        end
        chk("div255.high",  32'(hi),  32'd128);
        chk("div255.high0", 32'(hi0), 32'd127);
        chk("div255.ticks", 32'(tk),  32'd1);
        chk("div255.ticks0",32'(tk0), 32'd1);
        chk("div255.run",   32'(rn),  32'd255);
        chk("div255.ratio", 32'(act_ratio), 32'd255);
        @(posedge clk);
        #1;
        chk("div255.wrap.div",  32'(div_clk), 32'd1);
        chk("div255.wrap.tick", 32'(tick),    32'd1);

        // Ratio 6 -> 3 mid high phase: 111000 completes, then 110 (odd-low: 100).
        do_reset();
        add(1'b1, 8'd6, 1'b1, 1'b1, 1'b1, 8'd6, 1'b1);
        add(1'b1, 8'd6, 1'b1, 1'b0, 1'b1, 8'd6, 1'b1);
        add(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 8'd6, 1'b1);
        add(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
        add(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
        add(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd6, 1'b0);
        add(1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1);
        add(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 8'd3, 1'b0);
        add(1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 8'd3, 1'b0);
        add(1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 8'd3, 1'b1);
        apply_vecs("chg6to3");

        // Enable dropped mid high phase at ratio 8: period completes, then bypass.
        do_reset();
        add(1'b1, 8'd8, 1'b1, 1'b1, 1'b1, 8'd8, 1'b1);
        add(1'b1, 8'd8, 1'b1, 1'b0, 1'b1, 8'd8, 1'b1);
        add(1'b0, 8'd8, 1'b1, 1'b0, 1'b1, 8'd8, 1'b1);
        add(1'b0, 8'd8, 1'b1, 1'b0, 1'b1, 8'd8, 1'b1);
        for (int k = 0; k < 4; k++)
            add(1'b0, 8'd8, 1'b0, 1'b0, 1'b1, 8'd8, 1'b0);
        add(1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b0, 8'd8, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        apply_vecs("endis");

        // Ratios 0 and 1 keep bypass; ratio 2 starts on the next edge.
        do_reset();
        for (int k = 0; k < 3; k++) add(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        for (int k = 0; k < 3; k++) add(1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        add(1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
        add(1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
        add(1'b1, 8'd2, 1'b1, 1'b1, 1'b1, 8'd2, 1'b1);
        add(1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
        apply_vecs("lowratio");

        // Ratio 7, asynchronous reset in the low phase, then fresh restart.
        do_reset();
        for (int k = 0; k < 6; k++)
            add(1'b1, 8'd7, (k < 4), (k == 0), 1'b1, 8'd7, (k < 3));
        apply_vecs("div7");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.run",   32'(running),   32'd0);
        chk("arst.tick",  32'(tick),      32'd0);
        chk("arst.ratio", 32'(act_ratio), 32'd0);
        chk("arst.divhi", 32'(div_clk),   32'd1);
        chk("arst.div0hi",32'(div_clk0),  32'd1);
        chk("arst.run0",  32'(running0),  32'd0);
        @(negedge clk);
        #1;
        chk("arst.divlo", 32'(div_clk),   32'd0);
        rst_n = 1'b1;
        add(1'b1, 8'd7, 1'b1, 1'b1, 1'b1, 8'd7, 1'b1);
        add(1'b1, 8'd7, 1'b1, 1'b0, 1'b1, 8'd7, 1'b1);
        apply_vecs("restart7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
